// File: rtl/kypd_pkg.sv
// Shared types and widths for the keypad event controller.
package kypd_pkg;

   localparam int KEY_W = 4;
   localparam int EVT_W = KEY_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      HELD,
      REPEAT
   } kypd_state_t;

   // One queued key event: auto-repeat flag above the key code.
   typedef struct packed {
      logic             rpt;
      logic [KEY_W-1:0] code;
   } kypd_evt_t;

endpackage

// File: rtl/kypd_evt_fifo.sv
// First-word fall-through event queue with a sticky drop flag.
// A push into a full queue succeeds only when the head is popped in the same cycle.
module kypd_evt_fifo
   import kypd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          sys_rst,
   input  logic                          push,
   input  logic [EVT_W-1:0]              din,
   input  logic                          pop,
   input  logic                          clr_overflow,
   output logic [EVT_W-1:0]              head,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

   logic [EVT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             wr_en;
   logic             rd_en;

   assign empty = (level == '0);
   assign full  = (level == DEPTH_L);
   assign rd_en = pop & ~empty;
   // When full, the slot being written is the one the head vacates this edge.
   assign wr_en = push & (~full | rd_en);
   assign head  = empty ? '0 : mem[rd_ptr];

   // Pointer, occupancy and sticky drop-flag bookkeeping.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (push & ~wr_en)     overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   // Event storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/kypd_event_ctrl.sv
// Keypad event controller: qualifies decoder levels with a stability window,
// generates press and auto-repeat events, and queues them for the note player.
module kypd_event_ctrl
   import kypd_pkg::*;
#(
   parameter int STABLE_CYC       = 2_000_000,
   parameter int REPEAT_DELAY_CYC = 50_000_000,
   parameter int REPEAT_RATE_CYC  = 10_000_000,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                         clk,
   input  logic                         sys_rst,
   input  logic                         enable,
   input  logic [3:0]                   key_code,
   input  logic                         key_pressed,
   input  logic                         out_ready,
   input  logic                         clr_overflow,
   output logic                         out_valid,
   output logic [3:0]                   out_code,
   output logic                         out_repeat,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         overflow
);

   localparam int MAX_AB  = (STABLE_CYC > REPEAT_DELAY_CYC) ? STABLE_CYC : REPEAT_DELAY_CYC;
   localparam int MAX_CYC = (MAX_AB > REPEAT_RATE_CYC) ? MAX_AB : REPEAT_RATE_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(REPEAT_DELAY_CYC - 1);
   localparam logic [CNT_W-1:0] RATE_TC   = CNT_W'(REPEAT_RATE_CYC - 1);

   kypd_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [KEY_W-1:0] cand;
   logic             tc;
   logic             push;
   kypd_evt_t        push_evt;
   kypd_evt_t        head_evt;
   logic             fifo_empty;

   // Terminal count for the current state and the resulting push request.
   always_comb begin
      tc = 1'b0;
      case (state)
         DEBOUNCE: tc = (cnt == STABLE_TC);
         HELD:     tc = (cnt == DELAY_TC);
         REPEAT:   tc = (cnt == RATE_TC);
         default:  tc = 1'b0;
      endcase
      push          = enable & key_pressed & (key_code == cand) & tc & (state != IDLE);
      push_evt.rpt  = (state != DEBOUNCE);
      push_evt.code = cand;
   end

   // Key-tracking FSM; counter restarts on every state entry and code change.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= '0;
      end else if (!enable) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (key_pressed) begin
                  cand  <= key_code;
                  state <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (!key_pressed) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (key_code != cand) begin
                  cand <= key_code;
                  cnt  <= '0;
               end else if (tc) begin
                  state <= HELD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD, REPEAT: begin
               if (!key_pressed) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (key_code != cand) begin
                  cand  <= key_code;
                  state <= DEBOUNCE;
                  cnt   <= '0;
               end else if (tc) begin
                  state <= REPEAT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   kypd_evt_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .sys_rst      (sys_rst),
      .push         (push),
      .din          (push_evt),
      .pop          (out_ready),
      .clr_overflow (clr_overflow),
      .head         (head_evt),
      .empty        (fifo_empty),
      .level        (fifo_level),
      .overflow     (overflow)
   );

   assign out_valid  = ~fifo_empty;
   assign out_code   = head_evt.code;
   assign out_repeat = head_evt.rpt;

endmodule
